// File: rtl/seq_div_8_if.sv
// seq_div_8_if: start/busy/done handshake and result bus
// between the iterative divider and its controller.
interface seq_div_8_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output A,
    output B,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/seq_div_8.sv
// seq_div_8: unsigned restoring divider, one quotient bit
// per clock; divide-by-zero completes at the accepting edge.
module seq_div_8 #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  seq_div_8_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             start_z;
  logic             start_nz;
  logic             run;
  logic             last;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;

  always_comb begin
    start_z  = (state_q == S_IDLE) && bus.start
             && (bus.B == '0);
    start_nz = (state_q == S_IDLE) && bus.start
             && (bus.B != '0);
    run      = (state_q == S_RUN);
    last     = run && (cnt_q == LAST);
  end

  // One restoring step: shift in the next dividend bit,
  // trial-subtract, keep the difference if it did not borrow.
  always_comb begin
    rem_sh = (rem_q << 1)
           | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    qbit   = ~diff[WIDTH];
    rem_nx = qbit ? diff : rem_sh;
    quo_nx = (quo_q << 1) | {{(WIDTH-1){1'b0}}, qbit};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_nz) state_d = S_RUN;
      S_RUN:  if (last)     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (1'b1)
      start_z: begin
        q_out_d = '1;
        r_out_d = bus.A;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
      end
      start_nz: begin
        dvd_d = bus.A;
        dvs_d = bus.B;
        quo_d = '0;
        rem_d = '0;
        cnt_d = '0;
      end
      run: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          q_out_d = quo_nx;
          r_out_d = rem_nx[WIDTH-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    bus.busy        = (state_q == S_RUN);
    bus.done        = done_q;
    bus.quotient    = q_out_q;
    bus.remainder   = r_out_q;
    bus.div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_div_8.sv
// tb_seq_div_8: scoreboard bench for seq_div_8 with directed
// cases and randomized divides against an arithmetic model.
module tb_seq_div_8;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_div_8_if #(.WIDTH(W)) bus ();

  seq_div_8 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [W-1:0] hq = '0;
  logic [W-1:0] hr = '0;
  logic         hz = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      tick();
      n++;
    end
    if (bus.busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input bit track);
    exp_t e;
    wait_idle();
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    if (track) begin
      if (b == '0) begin
        e.q   = '1;
        e.r   = a;
        e.z   = 1'b1;
        e.cyc = cyc;
      end else begin
        e.q   = a / b;
        e.r   = a % b;
        e.z   = 1'b0;
        e.cyc = cyc + W;
      end
      sb.push_back(e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_quotient"}, int'(bus.quotient), 0);
    chk({tag, "_remainder"}, int'(bus.remainder), 0);
    chk({tag, "_dbz"}, int'(bus.div_by_zero), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hq = '0;
      hr = '0;
      hz = 1'b0;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", int'(bus.quotient), int'(e.q));
        chk("remainder", int'(bus.remainder), int'(e.r));
        chk("div_by_zero", int'(bus.div_by_zero), int'(e.z));
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", int'(bus.busy), 0);
        hq = e.q;
        hr = e.r;
        hz = e.z;
      end
    end else begin
      chk("hold_quotient", int'(bus.quotient), int'(hq));
      chk("hold_remainder", int'(bus.remainder), int'(hr));
      chk("hold_dbz", int'(bus.div_by_zero), int'(hz));
    end
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_zero("reset");

    issue(8'd100, 8'd7, 1'b1);
    chk("busy_t0", int'(bus.busy), 1);
    for (int i = 1; i < W; i++) begin
      tick();
      chk("busy_run", int'(bus.busy), 1);
    end
    tick();
    chk("busy_end", int'(bus.busy), 0);
    chk("done_end", int'(bus.done), 1);

    issue(8'd255, 8'd1, 1'b1);
    issue(8'd5, 8'd200, 1'b1);
    issue(8'd0, 8'd9, 1'b1);
    issue(8'd37, 8'd0, 1'b1);
    chk("busy_dbz", int'(bus.busy), 0);
    chk("done_dbz", int'(bus.done), 1);
    issue(8'd100, 8'd3, 1'b1);

    issue(8'd200, 8'd3, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("abort");
    repeat (12) tick();
    issue(8'd200, 8'd3, 1'b1);

    issue(8'd100, 8'd7, 1'b1);
    repeat (2) tick();
    bus.start = 1'b1;
    bus.A     = 8'd9;
    bus.B     = 8'd3;
    tick();
    bus.start = 1'b0;
    issue(8'd9, 8'd3, 1'b1);

    for (int k = 0; k < 1000; k++) begin
      issue(W'($urandom), W'($urandom_range(1, 255)), 1'b1);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) tick();
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (sb.size() != 0) chk("drain", sb.size(), 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
